// File: rtl/irrigation_zone_timer.sv
// irrigation_zone_timer: per-zone irrigation countdown with shared 1 s prescaler and clear arbitration
module irrigation_zone_timer #(
    parameter int CHANNELS = 2,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [CHANNELS-1:0]       i_irrigation_on,
    input  logic [CHANNELS-1:0]       i_irrigation_switch_pulse,
    input  logic [CHANNELS-1:0]       i_conflicting_values,
    input  logic                      i_forced_reset_from_button,
    input  logic [CHANNELS*DUR_W-1:0] i_duration,
    output logic [CHANNELS-1:0]       o_running,
    output logic [CHANNELS-1:0]       o_expired,
    output logic [CHANNELS*DUR_W-1:0] o_remaining,
    output logic [CHANNELS-1:0]       o_timer_reset,
    output logic                      o_tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    assign w_tick = r_cnt == CNT_W'(TICK_DIV - 1);
    assign o_tick = w_tick;
    // shared free-running prescaler, only reset restarts it
    always_ff @(posedge i_clock) begin
        if (i_reset) r_cnt <= '0;
        else         r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           r_state, w_next;
        logic [DUR_W-1:0] r_rem, w_rem_next, w_dur;
        logic             r_exp, w_exp_next, r_trst, w_clr;
        assign w_dur = i_duration[i*DUR_W +: DUR_W];
        assign w_clr = ~i_irrigation_on[i] | ~i_forced_reset_from_button
                     | i_conflicting_values[i] | i_irrigation_switch_pulse[i];
        // next state: clear always beats tick/expiry; load only from IDLE
        always_comb begin
            w_next     = r_state;
            w_rem_next = r_rem;
            w_exp_next = 1'b0;
            case (r_state)
                IDLE: if (!w_clr) begin
                    w_rem_next = w_dur;
                    w_next     = |w_dur ? RUN : DONE;
                    w_exp_next = ~|w_dur;
                end
                RUN: if (w_clr) begin
                    w_next     = IDLE;
                    w_rem_next = '0;
                end else if (w_tick) begin
                    w_rem_next = r_rem - DUR_W'(1);
                    w_next     = r_rem == DUR_W'(1) ? DONE : RUN;
                    w_exp_next = r_rem == DUR_W'(1);
                end
                DONE: w_next = w_clr ? IDLE : DONE;
                default: begin
                    w_next     = IDLE;
                    w_rem_next = '0;
                end
            endcase
        end
        // channel state, counter, expiry pulse and registered clear
        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_state <= IDLE;
                r_rem   <= '0;
                r_exp   <= 1'b0;
                r_trst  <= 1'b0;
            end else begin
                r_state <= w_next;
                r_rem   <= w_rem_next;
                r_exp   <= w_exp_next;
                r_trst  <= w_clr;
            end
        end
        assign o_running[i]                 = r_state == RUN;
        assign o_expired[i]                 = r_exp;
        assign o_timer_reset[i]             = r_trst;
        assign o_remaining[i*DUR_W +: DUR_W] = r_rem;
    end
endmodule

// File: tb/tb_irrigation_zone_timer.sv
// tb_irrigation_zone_timer: scoreboard bench for irrigation_zone_timer with directed vectors
module tb_irrigation_zone_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  on = 2'b00, pulse = 2'b00, conflict = 2'b00;
    logic        button = 1'b1;
    logic [15:0] dur = '0;
    logic [1:0]  running, expired, trst;
    logic [15:0] remaining;
    logic        tick;
    int          cyc = 0, checks = 0, errors = 0;
    typedef struct { int cyc; int sel; int val; } exp_t;
    exp_t        sb[$];
    string       nm[6] = '{"running", "remaining0", "remaining1", "timer_reset", "tick", "expired"};

    irrigation_zone_timer #(.CHANNELS(2), .DUR_W(8), .TICK_DIV(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_irrigation_on(on),
        .i_irrigation_switch_pulse(pulse), .i_conflicting_values(conflict),
        .i_forced_reset_from_button(button), .i_duration(dur),
        .o_running(running), .o_expired(expired), .o_remaining(remaining),
        .o_timer_reset(trst), .o_tick(tick));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0: return {30'd0, running};
            1: return {24'd0, remaining[7:0]};
            2: return {24'd0, remaining[15:8]};
            3: return {30'd0, trst};
            4: return {31'd0, tick};
            default: return {30'd0, expired};
        endcase
    endfunction

    task automatic expect_at(int d, int sel, int val);
        sb.push_back('{cyc + d, sel, val});
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit exp_seen;
        exp_seen = 1'b0;
        for (int k = 0; k < sb.size();) begin
            if (sb[k].cyc == cyc) begin
                checks++;
                if (actual(sb[k].sel) !== sb[k].val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %0d expected %0d", nm[sb[k].sel], cyc, actual(sb[k].sel), sb[k].val);
                end
                if (sb[k].sel == 5) exp_seen = 1'b1;
                sb.delete(k);
            end else k++;
        end
        if (!exp_seen && expired != 2'b00) begin
            checks++;
            errors++;
            $display("FAIL spurious_expired cycle %0d: got %b expected 00", cyc, expired);
        end
    end

    initial begin
        step(3);
        rst = 1'b0; on = 2'b01; dur[7:0] = 8'd3;
        expect_at(0, 0, 0); expect_at(0, 1, 0); expect_at(0, 3, 0); expect_at(0, 4, 0); expect_at(0, 5, 0);
        expect_at(1, 0, 1); expect_at(1, 1, 3); expect_at(1, 3, 2); expect_at(3, 4, 1);
        expect_at(4, 1, 2); expect_at(8, 1, 1); expect_at(11, 0, 1);
        expect_at(12, 0, 0); expect_at(12, 5, 1); expect_at(12, 1, 0); expect_at(13, 5, 0);
        step(5);
        dur[7:0] = 8'd9;
        step(8);
        pulse = 2'b01; dur[7:0] = 8'd2;
        expect_at(1, 0, 0); expect_at(1, 1, 0); expect_at(1, 3, 3);
        expect_at(2, 0, 1); expect_at(2, 1, 2); expect_at(2, 3, 2); expect_at(2, 4, 1);
        expect_at(3, 1, 1); expect_at(7, 5, 1); expect_at(7, 1, 0);
        step(1);
        pulse = 2'b00;
        step(7);
        on = 2'b11; dur[15:8] = 8'd0;
        expect_at(0, 5, 0); expect_at(1, 5, 2); expect_at(1, 0, 0); expect_at(1, 3, 0); expect_at(2, 5, 0);
        step(2);
        dur[7:0] = 8'd3; pulse = 2'b01;
        step(1);
        pulse = 2'b00;
        step(4);
        button = 1'b0;
        expect_at(0, 1, 2); expect_at(0, 0, 1);
        expect_at(1, 3, 3); expect_at(1, 0, 0); expect_at(1, 1, 0); expect_at(1, 5, 0);
        expect_at(2, 0, 1); expect_at(2, 1, 3); expect_at(2, 3, 0); expect_at(2, 5, 2);
        step(1);
        button = 1'b1;
        step(10);
        conflict = 2'b01;
        expect_at(0, 4, 1); expect_at(0, 1, 1);
        expect_at(1, 0, 0); expect_at(1, 1, 0); expect_at(1, 5, 0); expect_at(1, 3, 1);
        expect_at(2, 0, 1); expect_at(2, 1, 3);
        step(1);
        conflict = 2'b00;
        step(1);
        pulse = 2'b10; dur[15:8] = 8'd2;
        step(1);
        pulse = 2'b00;
        step(2);
        rst = 1'b1;
        expect_at(0, 0, 3); expect_at(0, 1, 2); expect_at(0, 2, 1);
        expect_at(1, 0, 0); expect_at(1, 1, 0); expect_at(1, 2, 0); expect_at(1, 3, 0);
        expect_at(1, 4, 0); expect_at(1, 5, 0);
        expect_at(2, 4, 0); expect_at(3, 4, 0); expect_at(4, 4, 1);
        step(1);
        rst = 1'b0;
        step(6);
        foreach (sb[k]) begin
            checks++;
            errors++;
            $display("FAIL %s never checked: expected %0d at cycle %0d", nm[sb[k].sel], sb[k].val, sb[k].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
